// File: rtl/icache_line_fetcher.sv
// Direct-mapped instruction cache: 32-bit hits from IF, one 16-byte line refill per miss.
// Optional hit/miss counters enabled by defining ICACHE_STAT_EN.
module icache_line_fetcher #(
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  output logic              icache_fc_valid,
  output logic [ADDR_W-1:0] icache_fc_addr,
  input  logic              icache_fc_done,
  input  logic [127:0]      icache_fc_line
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [127:0]       r_data [LINES];
  logic [IDX_W-1:0]   r_pend_idx;
  logic [TAG_W-1:0]   r_pend_tag;
  logic [1:0]         r_pend_word;
  logic               r_kill;
  logic               r_done;
  logic [31:0]        r_inst;
  logic               r_fc_valid;
  logic [ADDR_W-1:0]  r_fc_addr;
`ifdef ICACHE_STAT_EN
  logic [31:0]        r_stat_hit;
  logic [31:0]        r_stat_miss;
`endif

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_word;
  logic               w_hit;
  logic               w_fill;
  logic               w_unused;

  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
    case (sel)
      2'd0:    line_word = line[31:0];
      2'd1:    line_word = line[63:32];
      2'd2:    line_word = line[95:64];
      default: line_word = line[127:96];
    endcase
  endfunction

  assign w_word   = if_pc[3:2];
  assign w_idx    = if_pc[4 +: IDX_W];
  assign w_tag    = if_pc[ADDR_W-1 -: TAG_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill   = rdy && (r_state == S_WAIT) && icache_fc_done;
  assign w_unused = ^if_pc[1:0];

  // Tag and data storage carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_pend_idx] <= icache_fc_line;
      r_tag[r_pend_idx]  <= r_pend_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_done      <= 1'b0;
      r_inst      <= '0;
      r_fc_valid  <= 1'b0;
      r_fc_addr   <= '0;
      r_kill      <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_tag  <= '0;
      r_pend_word <= '0;
`ifdef ICACHE_STAT_EN
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (rdy) begin
        case (r_state)
          S_IDLE: begin
            if (if_req && !if_flush) begin
              if (w_hit) begin
                r_done <= 1'b1;
                r_inst <= line_word(r_data[w_idx], w_word);
`ifdef ICACHE_STAT_EN
                r_stat_hit <= r_stat_hit + 32'd1;
`endif
              end else begin
                r_fc_valid  <= 1'b1;
                r_fc_addr   <= {if_pc[ADDR_W-1:4], 4'b0000};
                r_pend_idx  <= w_idx;
                r_pend_tag  <= w_tag;
                r_pend_word <= w_word;
                r_kill      <= 1'b0;
                r_state     <= S_WAIT;
`ifdef ICACHE_STAT_EN
                r_stat_miss <= r_stat_miss + 32'd1;
`endif
              end
            end
          end
          S_WAIT: begin
            // A flushed fetch still completes and installs; only the reply is dropped.
            if (icache_fc_done) begin
              r_fc_valid          <= 1'b0;
              r_valid[r_pend_idx] <= 1'b1;
              if (!r_kill && !if_flush) begin
                r_done <= 1'b1;
                r_inst <= line_word(icache_fc_line, r_pend_word);
              end
              r_state <= S_IDLE;
            end else if (if_flush) begin
              r_kill <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign if_done         = r_done;
  assign if_inst         = r_inst;
  assign icache_fc_valid = r_fc_valid;
  assign icache_fc_addr  = r_fc_addr;
`ifdef ICACHE_STAT_EN
  assign stat_hit        = r_stat_hit;
  assign stat_miss       = r_stat_miss;
`endif

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Directed bench for icache_line_fetcher with a queue of expected instruction words.
module tb_icache_line_fetcher;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic         if_req;
  logic [31:0]  if_pc;
  logic         if_flush;
  logic         if_done;
  logic [31:0]  if_inst;
  logic         icache_fc_valid;
  logic [31:0]  icache_fc_addr;
  logic         icache_fc_done;
  logic [127:0] icache_fc_line;
`ifdef ICACHE_STAT_EN
  logic [31:0]  stat_hit;
  logic [31:0]  stat_miss;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  icache_line_fetcher #(.IDX_W(6), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .if_req          (if_req),
    .if_pc           (if_pc),
    .if_flush        (if_flush),
    .if_done         (if_done),
    .if_inst         (if_inst),
    .icache_fc_valid (icache_fc_valid),
    .icache_fc_addr  (icache_fc_addr),
    .icache_fc_done  (icache_fc_done),
    .icache_fc_line  (icache_fc_line)
`ifdef ICACHE_STAT_EN
    ,
    .stat_hit        (stat_hit),
    .stat_miss       (stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing-store contents: distinct word per address, with the cold-miss word pinned.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h0000_1004) return 32'h00A0_0093;
    return {wa[15:2], 2'b11, ~wa[15:0]};
  endfunction

  function automatic logic [127:0] mk_line(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word(la + 32'(4 * w));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit later and score any if_done pulse.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (if_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(if_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("inst", if_inst, e);
      end
    end
  endtask

  task automatic hit_fetch(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    exp_q.push_back(mem_word(pc));
    tick();
    chk("hit_done", 32'(if_done), 32'd1);
    chk("hit_fc_idle", 32'(icache_fc_valid), 32'd0);
    if_req = 1'b0;
  endtask

  task automatic miss_fetch(input logic [31:0] pc, input int lat);
    logic [31:0] la;
    la     = {pc[31:4], 4'b0000};
    if_req = 1'b1;
    if_pc  = pc;
    tick();
    chk("miss_fc_valid", 32'(icache_fc_valid), 32'd1);
    chk("miss_fc_addr", icache_fc_addr, la);
    chk("miss_no_done", 32'(if_done), 32'd0);
    repeat (lat) begin
      tick();
      chk("wait_fc_valid", 32'(icache_fc_valid), 32'd1);
      chk("wait_fc_addr", icache_fc_addr, la);
    end
    exp_q.push_back(mem_word(pc));
    icache_fc_done = 1'b1;
    icache_fc_line = mk_line(la);
    tick();
    chk("refill_done", 32'(if_done), 32'd1);
    chk("refill_fc_clr", 32'(icache_fc_valid), 32'd0);
    icache_fc_done = 1'b0;
    if_req         = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_pc = '0; if_flush = 1'b0;
    icache_fc_done = 1'b0; icache_fc_line = '0;

    // Reset state
    tick(); tick();
    chk("rst_done", 32'(if_done), 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_fc_valid", 32'(icache_fc_valid), 32'd0);
    chk("rst_fc_addr", icache_fc_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss, then hit in the same line
    miss_fetch(32'h0000_1004, 2);
    chk("cold_inst", if_inst, 32'h00A0_0093);
    tick();
    hit_fetch(32'h0000_1008);

    // Conflict on index 0 evicts and re-misses
    miss_fetch(32'h0000_1400, 1);
    miss_fetch(32'h0000_1004, 0);
    hit_fetch(32'h0000_100C);

    // Index wrap aliasing
    miss_fetch(32'h0000_0400, 1);
    miss_fetch(32'h0000_0000, 1);
    hit_fetch(32'h0000_0404 - 32'h400);

    // Flush in IDLE drops the request
    if_req = 1'b1; if_pc = 32'h0000_3020; if_flush = 1'b1;
    tick();
    chk("idle_flush_fc", 32'(icache_fc_valid), 32'd0);
    chk("idle_flush_done", 32'(if_done), 32'd0);
    if_req = 1'b0; if_flush = 1'b0;
    tick();
    chk("idle_flush_after", 32'(icache_fc_valid), 32'd0);

    // Flush two cycles into WAIT, fill arrives 18 cycles after the request
    if_req = 1'b1; if_pc = 32'h0000_2000;
    tick();
    chk("fl_fc_valid", 32'(icache_fc_valid), 32'd1);
    tick(); tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    if_req = 1'b1; if_pc = 32'h0000_1008;
    repeat (3) begin
      tick();
      chk("fl_req_ignored", 32'(if_done), 32'd0);
    end
    if_req = 1'b0;
    repeat (11) begin
      tick();
      chk("fl_hold_valid", 32'(icache_fc_valid), 32'd1);
      chk("fl_hold_addr", icache_fc_addr, 32'h0000_2000);
    end
    icache_fc_done = 1'b1; icache_fc_line = mk_line(32'h0000_2000);
    tick();
    chk("fl_no_done", 32'(if_done), 32'd0);
    chk("fl_fc_clr", 32'(icache_fc_valid), 32'd0);
    icache_fc_done = 1'b0;
    hit_fetch(32'h0000_2000);

    // Flush coincident with the fill
    if_req = 1'b1; if_pc = 32'h0000_3020;
    tick();
    chk("co_fc_valid", 32'(icache_fc_valid), 32'd1);
    tick();
    icache_fc_done = 1'b1; icache_fc_line = mk_line(32'h0000_3020); if_flush = 1'b1;
    tick();
    chk("co_no_done", 32'(if_done), 32'd0);
    chk("co_fc_clr", 32'(icache_fc_valid), 32'd0);
    icache_fc_done = 1'b0; if_flush = 1'b0; if_req = 1'b0;
    hit_fetch(32'h0000_3024);

    // Stall while WAIT, then complete
    if_req = 1'b1; if_pc = 32'h0000_4030;
    tick();
    chk("st_fc_valid", 32'(icache_fc_valid), 32'd1);
    rdy = 1'b0;
    repeat (5) begin
      tick();
      chk("st_hold_valid", 32'(icache_fc_valid), 32'd1);
      chk("st_hold_addr", icache_fc_addr, 32'h0000_4030);
      chk("st_no_done", 32'(if_done), 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("st_still_wait", 32'(icache_fc_valid), 32'd1);
    exp_q.push_back(mem_word(32'h0000_4030));
    icache_fc_done = 1'b1; icache_fc_line = mk_line(32'h0000_4030);
    tick();
    chk("st_done", 32'(if_done), 32'd1);
    chk("st_fc_clr", 32'(icache_fc_valid), 32'd0);
    icache_fc_done = 1'b0; if_req = 1'b0;

    // Frozen hit produces nothing until rdy returns
    rdy = 1'b0; if_req = 1'b1; if_pc = 32'h0000_4034;
    tick();
    chk("frz_no_done", 32'(if_done), 32'd0);
    exp_q.push_back(mem_word(32'h0000_4034));
    rdy = 1'b1;
    tick();
    chk("frz_done", 32'(if_done), 32'd1);
    if_req = 1'b0;

    // Async reset in the middle of WAIT invalidates the cache
    miss_fetch(32'h0000_1000, 1);
    hit_fetch(32'h0000_1004);
    if_req = 1'b1; if_pc = 32'h0000_5010;
    tick();
    chk("ar_fc_valid", 32'(icache_fc_valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("ar_fc_clr", 32'(icache_fc_valid), 32'd0);
    chk("ar_fc_addr", icache_fc_addr, 32'd0);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    miss_fetch(32'h0000_1000, 1);

    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_line_fetcher.md
Name: icache_line_fetcher

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller's line-fetch port.
- Serves 32-bit instruction reads on hit; on miss, requests one 16-byte line via the fc handshake and refills.
- The memory controller is the responder on the fc interface; this block is the initiator.

Parameters:
- IDX_W, 6, index bits (2^IDX_W lines of 16 B); tag = 32-4-IDX_W bits.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low: asserted when 0.
- rdy  in  1  global ready; 0 freezes all state.
- if_req  in  1  fetch request; held with if_pc stable until if_done or if_flush.
- if_pc  in  ADDR_W  fetch address; bits[1:0] ignored.
- if_flush  in  1  rollback: abandon the outstanding request.
- if_done  out  1  one-cycle pulse, if_inst valid.
- if_inst  out  32  instruction word.
- icache_fc_valid  out  1  line fetch request to memctrl.
- icache_fc_addr  out  ADDR_W  line address, bits[3:0]=0.
- icache_fc_done  in  1  one-cycle pulse from memctrl, line valid.
- icache_fc_line  in  128  line, byte 0 in bits[7:0].

Behaviour:
- Reset (rst=0, async): all valid bits=0; state=IDLE; if_done=0; if_inst=0; icache_fc_valid=0; icache_fc_addr=0; kill=0. Tag and data arrays are not reset.
- if_done is cleared every clock edge unless set below. rdy=0 freezes everything else, and if_done=0 during freeze.
- Address split: off=pc[3:0], word=pc[3:2], idx=pc[4+IDX_W-1:4], tag=pc[ADDR_W-1:4+IDX_W].
- States:
  - IDLE: requests are accepted here.
  - WAIT: fc request outstanding.
- IDLE, if_req=1, if_flush=0:
  - Hit (valid[idx] and tag match): next edge if_done=1, if_inst=data[idx] word[word]. Latency 1 cycle.
  - Miss: next edge icache_fc_valid=1, icache_fc_addr={pc[ADDR_W-1:4],4'b0}; latch pending idx/tag/word; kill=0; go to WAIT.
- IDLE with if_flush=1: the request is ignored, and no if_done follows it.
- WAIT:
  - icache_fc_valid and icache_fc_addr are held constant until icache_fc_done.
  - On icache_fc_done=1, the same edge:
    - data[idx]=line, tag[idx]=pending tag, valid[idx]=1.
    - icache_fc_valid=0.
    - If kill=0 and if_flush=0: if_done=1, if_inst=line word[pending word].
    - Go to IDLE.
  - Clearing icache_fc_valid on the done edge is mandatory. Memctrl re-launches if valid is still high one cycle after done.
- Flush in WAIT:
  - Set kill=1. The fetch cannot be aborted, so icache_fc_valid stays 1 until done.
  - The line is still installed; if_done is suppressed.
  - New if_req is ignored until back in IDLE.
- Flush coincident with icache_fc_done: the refill is installed and if_done is suppressed.
- The cycle after returning to IDLE, a request to the same line hits.
- Line replacement: direct-mapped overwrite, no eviction writeback (read-only cache).
- Index wrap: pc 0x0000_0400 and 0x0000_0000 alias when IDX_W=6.

Optional Feature:
- Macro ICACHE_STAT_EN.
- Defined:
  - Adds outputs stat_hit (32) and stat_miss (32); reset to 0.
  - stat_hit += 1 per hit if_done in IDLE.
  - stat_miss += 1 per transition IDLE->WAIT. Killed misses still count.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, if_req with pc=0x0000_1004 -> icache_fc_valid=1, addr=0x0000_1000 next cycle. fc_done with line word1=0x00A00093 -> if_done=1, if_inst=0x00A00093 the same edge; icache_fc_valid=0.
- Hit: then pc=0x0000_1008 -> if_done 1 cycle later, if_inst=line word2, icache_fc_valid stays 0.
- Conflict: pc=0x0000_1400 (same idx, different tag) -> miss and refill. pc=0x0000_1004 then misses again.
- Flush in WAIT: miss at 0x2000, if_flush 2 cycles later. fc_done after 18 cycles -> no if_done; icache_fc_valid deasserts exactly on the done edge. Next pc=0x2000 hits in 1 cycle.
- Stall: rdy=0 for 5 cycles during WAIT -> icache_fc_valid/addr unchanged, no if_done. On rdy=1 the flow completes normally.
- Async reset mid-WAIT: rst=0 between edges -> icache_fc_valid=0 immediately; a prior line at 0x1000 now misses.
